i2c_master: RTL and testbench
=============================

Name: i2c_master

Overview:
Single-byte I2C master (initiator) for the DE1-SoC fabric; the controller end of the bus served by the team's i2c_slave.
- Accepts one command from local logic: 7-bit address, R/W bit, and a write byte.
- Generates START, address, data, ACK/NACK and STOP on open-drain sda/scl.
- Returns the read byte and an ACK-error flag.
- Standard-mode timing derived from sysclk by a quarter-bit divider.

Parameters:
- CLK_DIV, 125, sysclk cycles per quarter-bit tick (50 MHz / (4 x 125) = 100 kHz SCL); legal range >= 2.

Ports:
- sysclk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle command strobe; accepted only when busy=0
- rw  in  1  0 = write, 1 = read; sampled with start
- addr  in  7  target address; sampled with start
- wdata  in  8  byte to write; sampled with start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the transaction ends (after STOP)
- ack_err  out  1  valid with done; 1 = address or data byte NACKed
- rdata  out  8  read byte; valid with done when rw=1; holds until the next read
- sda  inout  1  open drain: driven 0 or z, never 1
- scl  inout  1  open drain: driven 0 or z, never 1

Behaviour:
- Reset (asynchronous, immediate): busy=0, done=0, ack_err=0, rdata=8'h00, sda=z, scl=z, state IDLE, divider cleared. Reset mid-transaction releases both lines immediately and does not emit a STOP.
- Inputs sda and scl pass through 2-flop synchronizers; all sampling uses the synchronized values.
- Tick: one-cycle pulse every CLK_DIV sysclk cycles while busy. The divider restarts at 0 on an accepted start.
- Bit slot = 4 ticks, phases q0..q3:
  - q0: scl low, sda updated.
  - q1: scl released.
  - q2: sda sampled.
  - q3: scl still released; scl pulled low at the end of q3.
- States: IDLE, START, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RNACK, STOP.
- IDLE: sda=z, scl=z. On start: latch addr/rw/wdata, go to START, busy=1 next cycle. While busy, start is ignored.
- START, one slot: q0-q1 both released; q2 sda=0 with scl high; q3 scl=0.
- ADDR, 8 slots: shifts {addr, rw} MSB first (addr[6] first, rw last).
- ADDR_ACK: sda released; sample at q2.
  - 0 (ACK): go to WDATA if rw=0, RDATA if rw=1.
  - 1 (NACK): set ack_err and go to STOP.
- WDATA, 8 slots: wdata MSB first.
- WDATA_ACK: sample at q2; 1 sets ack_err. Then STOP.
- RDATA, 8 slots: sda released; shift the sampled bit in at each q2, MSB first. rdata updates at the end of the 8th slot.
- RNACK: master leaves sda released (NACK, single-byte read). Then STOP.
- STOP, one slot: q0 sda=0, scl=0; q1 scl released; q2 sda released with scl high; q3 idle.
- done=1 in the cycle after the STOP q3 tick; busy falls in the same cycle; return to IDLE.
- Latency with no stretching: full transaction = 20 slots = 80 x CLK_DIV cycles; address-NACK transaction = 11 slots = 44 x CLK_DIV cycles. There is no extra pipeline delay beyond the done cycle.
- ack_err clears on the next accepted start.
- No arbitration or multi-master support. A bus already low at start is not detected.

Optional Feature:
- I2C_CLK_STRETCH_EN defined: in q1 of every slot (including START and STOP), the divider holds while synchronized scl reads 0. The phase advances only after scl is seen high, so latency grows by the stretch time.
- Not defined: the divider free-runs and synchronized scl is ignored.

Decomposition:
- Package i2c_pkg:
  - state enum i2c_state_t.
  - RW_WRITE=1'b0, RW_READ=1'b1.
  - 2-bit phase type.
  - I2C_ADDR_W=7, I2C_DATA_W=8.
  - i2c_slave also imports the package.
- Sub-module i2c_tick_gen: CLK_DIV counter with enable, clear and hold inputs; outputs the tick pulse.

Test Plan:
- Write, CLK_DIV=4, addr=7'h1c, wdata=8'hA5, slave model ACKs both bytes -> bus bits 0x38 then 0xA5, done after 320 cycles, ack_err=0, exactly one START and one STOP.
- Read, addr=7'h1c, slave returns 8'h3C -> address byte 0x39, rdata=8'h3C with done, master leaves sda high in the 9th data slot (NACK), then STOP.
- Address NACK, addr=7'h22 with no responder -> ack_err=1, STOP follows the ACK slot, done after 176 cycles, no data slots.
- start pulsed again mid-transaction with addr=7'h55 -> ignored; the original transaction completes unchanged and the bus never shows 7'h55.
- rst asserted in the 4th address bit -> sda=z and scl=z within the reset cycle, busy=0, done never pulses; a following start runs normally.
- I2C_CLK_STRETCH_EN defined, slave holds scl low 50 cycles in slot 3 -> phase is frozen for the stretch, done arrives 50 cycles later than the 320-cycle baseline, all bits correct.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C master and slave blocks.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // Quarter-bit phase inside one bit slot (q0..q3).
    typedef logic [1:0] i2c_phase_t;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RNACK,
        STOP
    } i2c_state_t;

endpackage

// File: rtl/i2c_if.sv
// i2c_if: command/status bundle between local logic (master modport) and i2c_master (slave modport).
// Handshake: start is a one-cycle strobe taken only while busy==0, with rw/addr/wdata valid in that cycle; done pulses once per accepted start, with ack_err/rdata valid in that cycle.
interface i2c_if;
    import i2c_pkg::*;

    logic                  start;
    logic                  rw;
    logic [I2C_ADDR_W-1:0] addr;
    logic [I2C_DATA_W-1:0] wdata;
    logic                  busy;
    logic                  done;
    logic                  ack_err;
    logic [I2C_DATA_W-1:0] rdata;
    i2c_state_t            dbg_state;

    modport master (
        output start, rw, addr, wdata,
        input  busy, done, ack_err, rdata, dbg_state
    );

    modport slave (
        input  start, rw, addr, wdata,
        output busy, done, ack_err, rdata, dbg_state
    );

endinterface

// File: rtl/i2c_tick_gen.sv
// i2c_tick_gen: quarter-bit tick divider; one-cycle tick every CLK_DIV sysclk cycles while enabled.
module i2c_tick_gen #(
    parameter int CLK_DIV = 125
) (
    input  logic sysclk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          at_last;

    assign at_last = (cnt == LAST);
    assign tick    = en && at_last && !hold;

    // hold only freezes the terminal count, so the synchronizer lag after scl
    // is released does not lengthen an unstretched phase.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (!(at_last && hold)) begin
            cnt <= at_last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C initiator driving open-drain sda/scl with 4-phase bit slots.
// Define I2C_CLK_STRETCH_EN to let a slave stretch scl during q1 of every slot.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic sysclk,
    input  logic rst,
    i2c_if.slave bus,
    inout  wire  sda,
    inout  wire  scl
);

    i2c_state_t            state, state_n;
    i2c_phase_t            phase, phase_n;
    logic [2:0]            bitn, bitn_n;
    logic [I2C_DATA_W-1:0] sh, sh_n, wd_q, wd_n, rdata_q, rdata_n;
    logic                  rw_q, rw_n, ack_err_q, ack_err_n, done_q, done_n;
    logic                  sda_low, scl_low, clr, hold, tick, run;
    logic                  slot_end, sample, sda_s;
    logic [1:0]            sda_sync;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) sda_sync <= 2'b11;
        else     sda_sync <= {sda_sync[0], sda};
    end
    assign sda_s = sda_sync[1];

`ifdef I2C_CLK_STRETCH_EN
    logic [1:0] scl_sync;
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) scl_sync <= 2'b11;
        else     scl_sync <= {scl_sync[0], scl};
    end
    assign hold = run && (phase == 2'd1) && !scl_sync[1];
`else
    assign hold = 1'b0;
`endif

    assign run      = (state != IDLE);
    assign slot_end = tick && (phase == 2'd3);
    assign sample   = tick && (phase == 2'd2);

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .sysclk (sysclk),
        .rst    (rst),
        .en     (run),
        .clr    (clr),
        .hold   (hold),
        .tick   (tick)
    );

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            phase     <= '0;
            bitn      <= '0;
            sh        <= '0;
            wd_q      <= '0;
            rw_q      <= RW_WRITE;
            ack_err_q <= 1'b0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            bitn      <= bitn_n;
            sh        <= sh_n;
            wd_q      <= wd_n;
            rw_q      <= rw_n;
            ack_err_q <= ack_err_n;
            rdata_q   <= rdata_n;
            done_q    <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        phase_n   = phase;
        bitn_n    = bitn;
        sh_n      = sh;
        wd_n      = wd_q;
        rw_n      = rw_q;
        ack_err_n = ack_err_q;
        rdata_n   = rdata_q;
        done_n    = 1'b0;
        sda_low   = 1'b0;
        scl_low   = 1'b0;
        clr       = 1'b0;
        if (tick) phase_n = phase + 2'd1;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n   = START;
                    sh_n      = {bus.addr, bus.rw};
                    wd_n      = bus.wdata;
                    rw_n      = bus.rw;
                    ack_err_n = 1'b0;
                    phase_n   = '0;
                    bitn_n    = '0;
                    clr       = 1'b1;
                end
            end
            START: begin
                sda_low = phase[1];
                scl_low = (phase == 2'd3);
                if (slot_end) state_n = ADDR;
            end
            ADDR, WDATA: begin
                scl_low = (phase == 2'd0);
                sda_low = !sh[7];
                if (slot_end) begin
                    sh_n   = {sh[6:0], 1'b0};
                    bitn_n = bitn + 3'd1;
                    if (bitn == 3'd7) state_n = (state == ADDR) ? ADDR_ACK : WDATA_ACK;
                end
            end
            ADDR_ACK, WDATA_ACK: begin
                scl_low = (phase == 2'd0);
                if (sample && sda_s) ack_err_n = 1'b1;
                // ack_err was cleared at start, so here it reflects this slot's sample.
                if (slot_end) begin
                    if (state == WDATA_ACK || ack_err_q) begin
                        state_n = STOP;
                    end else if (rw_q == RW_WRITE) begin
                        state_n = WDATA;
                        sh_n    = wd_q;
                    end else begin
                        state_n = RDATA;
                    end
                end
            end
            RDATA: begin
                scl_low = (phase == 2'd0);
                if (sample) sh_n = {sh[6:0], sda_s};
                if (slot_end) begin
                    bitn_n = bitn + 3'd1;
                    if (bitn == 3'd7) begin
                        rdata_n = sh;
                        state_n = RNACK;
                    end
                end
            end
            RNACK: begin
                scl_low = (phase == 2'd0);
                if (slot_end) state_n = STOP;
            end
            STOP: begin
                sda_low = !phase[1];
                scl_low = (phase == 2'd0);
                if (slot_end) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign sda = sda_low ? 1'b0 : 1'bz;
    assign scl = scl_low ? 1'b0 : 1'bz;

    assign bus.busy      = run;
    assign bus.done      = done_q;
    assign bus.ack_err   = ack_err_q;
    assign bus.rdata     = rdata_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed + random transactions against a bit-level slave model and a frame scoreboard.
module tb_i2c_master;
    import i2c_pkg::*;

    localparam int         CLK_DIV  = 4;
    localparam logic [6:0] SLV_ADDR = 7'h1c;
    localparam int         STRETCH  = 50;

    logic sysclk = 1'b0;
    logic rst    = 1'b1;
    wire  sda, scl;
    logic slv_sda_low = 1'b0;
    logic slv_scl_low = 1'b0;

    pullup (sda);
    pullup (scl);
    assign sda = slv_sda_low ? 1'b0 : 1'bz;
    assign scl = slv_scl_low ? 1'b0 : 1'bz;

    i2c_if bus ();

    i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .sysclk (sysclk),
        .rst    (rst),
        .bus    (bus),
        .sda    (sda),
        .scl    (scl)
    );

    always #5 sysclk = ~sysclk;

    int total = 0;
    int bad   = 0;

    // Bus monitor and slave model state.
    logic       p_scl = 1'b1, p_sda = 1'b1;
    int         start_cnt = 0, stop_cnt = 0, done_cnt = 0;
    int         bitc = 0, rise_cnt = 0, stretch_left = 0;
    int         stretch_slot = 0, stretch_hold = 0;
    logic [8:0] shf = '0;
    logic       addr_hit = 1'b0, slv_rw = 1'b0;
    logic [7:0] slv_rdata = '0;
    logic       slv_wnack = 1'b0;
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] exp_rdata = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Frames are 9 bus bits after START: 8 data bits then the ack bit.
    always @(negedge sysclk) begin
        logic s_scl, s_sda;
        int   n;
        s_scl = (scl !== 1'b0);
        s_sda = (sda !== 1'b0);
        if (bus.done === 1'b1) done_cnt++;
        if (rst) begin
            slv_sda_low  = 1'b0;
            slv_scl_low  = 1'b0;
            stretch_left = 0;
        end else if (stretch_left > 0) begin
            stretch_left--;
            if (stretch_left == 0) slv_scl_low = 1'b0;
        end
        if (p_scl && s_scl && p_sda && !s_sda) begin
            start_cnt++;
            bitc     = 0;
            rise_cnt = 0;
            addr_hit = 1'b0;
        end else if (p_scl && s_scl && !p_sda && s_sda) begin
            stop_cnt++;
        end else if (!p_scl && s_scl) begin
            shf = {shf[7:0], s_sda};
            bitc++;
            rise_cnt++;
            if (bitc == 9) begin
                got_q.push_back(shf);
                bitc = 0;
            end
        end else if (p_scl && !s_scl && !rst) begin
            n = rise_cnt + 1;
            slv_sda_low = 1'b0;
            if (n == 9) begin
                addr_hit    = (shf[7:1] == SLV_ADDR);
                slv_rw      = shf[0];
                slv_sda_low = addr_hit;
            end else if (n >= 10 && n <= 17) begin
                slv_sda_low = addr_hit && (slv_rw == RW_READ) && !slv_rdata[17-n];
            end else if (n == 18) begin
                slv_sda_low = addr_hit && (slv_rw == RW_WRITE) && !slv_wnack;
            end
            if (n == stretch_slot) begin
                slv_scl_low  = 1'b1;
                stretch_left = stretch_hold;
            end
        end
        p_scl = s_scl;
        p_sda = s_sda;
    end

    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                           input logic [7:0] srd, input logic wnack, input int mid_at,
                           input int extra);
        logic hit, exp_err;
        int   exp_cyc, cyc, s0, p0;
        hit     = (a == SLV_ADDR);
        exp_err = !hit || (r == RW_WRITE && wnack);
        exp_cyc = (hit ? 80 : 44) * CLK_DIV + extra;
        if (hit && r == RW_READ) exp_rdata = srd;
        exp_q.delete();
        got_q.delete();
        exp_q.push_back({a, r, !hit});
        if (hit) exp_q.push_back((r == RW_READ) ? {srd, 1'b1} : {wd, wnack});
        slv_rdata = srd;
        slv_wnack = wnack;
        s0 = start_cnt;
        p0 = stop_cnt;
        @(negedge sysclk);
        bus.start = 1'b1;
        bus.addr  = a;
        bus.rw    = r;
        bus.wdata = wd;
        @(negedge sysclk);
        bus.start = 1'b0;
        bus.addr  = 7'($urandom);
        bus.wdata = 8'($urandom);
        check("busy_after_start", 32'(bus.busy), 32'(1));
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < exp_cyc + 400) begin
            @(negedge sysclk);
            cyc++;
            if (cyc == mid_at) begin
                bus.start = 1'b1;
                bus.addr  = 7'h55;
                bus.rw    = ~r;
                bus.wdata = ~wd;
            end else begin
                bus.start = 1'b0;
            end
        end
        check("done_latency", 32'(cyc), 32'(exp_cyc));
        check("ack_err", 32'(bus.ack_err), 32'(exp_err));
        check("rdata", 32'(bus.rdata), 32'(exp_rdata));
        check("busy_at_done", 32'(bus.busy), 32'(0));
        @(negedge sysclk);
        check("done_one_cycle", 32'(bus.done), 32'(0));
        repeat (4) @(negedge sysclk);
        check("frame_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("frame%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        check("start_conds", 32'(start_cnt - s0), 32'(1));
        check("stop_conds", 32'(stop_cnt - p0), 32'(1));
    endtask

    initial begin
        int d0;
        logic [6:0] ra;
        logic       rr, rn;
        bus.start = 1'b0;
        bus.rw    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;

        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge sysclk);
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_done", 32'(bus.done), 32'(0));
        check("rst_ack_err", 32'(bus.ack_err), 32'(0));
        check("rst_rdata", 32'(bus.rdata), 32'(0));
        check("rst_sda", 32'(sda), 32'(1));
        check("rst_scl", 32'(scl), 32'(1));
        check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
        rst = 1'b0;
        repeat (3) @(negedge sysclk);

        // Directed: write, read, address NACK, ignored mid-transaction start.
        run_txn(SLV_ADDR, RW_WRITE, 8'ha5, 8'h00, 1'b0, 0, 0);
        run_txn(SLV_ADDR, RW_READ,  8'h00, 8'h3c, 1'b0, 0, 0);
        run_txn(7'h22,    RW_WRITE, 8'h77, 8'h00, 1'b0, 0, 0);
        run_txn(SLV_ADDR, RW_WRITE, 8'h96, 8'h00, 1'b0, 100, 0);

        // Reset during q0 of the 4th address bit (scl held low by the master).
        d0 = done_cnt;
        @(negedge sysclk);
        bus.start = 1'b1;
        bus.addr  = SLV_ADDR;
        bus.rw    = RW_WRITE;
        bus.wdata = 8'h5a;
        @(negedge sysclk);
        bus.start = 1'b0;
        repeat (65) @(negedge sysclk);
        check("scl_low_before_rst", 32'(scl), 32'(0));
        rst = 1'b1;
        #1;
        check("midrst_sda", 32'(sda), 32'(1));
        check("midrst_scl", 32'(scl), 32'(1));
        check("midrst_busy", 32'(bus.busy), 32'(0));
        check("midrst_state", 32'(bus.dbg_state), 32'(IDLE));
        repeat (3) @(negedge sysclk);
        rst = 1'b0;
        repeat (20) @(negedge sysclk);
        check("no_done_after_rst", 32'(done_cnt - d0), 32'(0));
        exp_rdata = 8'h00;
        run_txn(SLV_ADDR, RW_WRITE, 8'hc3, 8'h00, 1'b0, 0, 0);

`ifdef I2C_CLK_STRETCH_EN
        // Slave grabs scl at the start of address slot 3. A release seen at the
        // negedge k cycles after the master's q1 begins reaches the master's
        // synchronizer so that q1 ends k-1 cycles late; hold time counts from the fall.
        stretch_slot = 3;
        stretch_hold = STRETCH + CLK_DIV + 1;
        run_txn(SLV_ADDR, RW_WRITE, 8'h5c, 8'h00, 1'b0, 0, STRETCH);
        stretch_slot = 0;
`endif

        // Random transactions: addresses mostly hit the slave, some data NACKs.
        for (int k = 0; k < 10; k++) begin
            ra = ($urandom_range(0, 2) == 0) ? 7'($urandom) : SLV_ADDR;
            rr = 1'($urandom_range(0, 1));
            rn = ($urandom_range(0, 3) == 0);
            run_txn(ra, rr, 8'($urandom), 8'($urandom), rn, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
